// File: rtl/piece_controller_if.sv
// Shared piece type plus the controller's generator/board-writer bus.
// Carries gen_t/gen_enable, the live piece, the lock handshake and game_over;
// ghost_y/ghost_valid are present only when PIECE_GHOST_EN is defined.

package piece_pkg;

    // data[rotation] is a 4x4 row-major mask, bit 15 = row 0 col 0.
    typedef struct packed {
        logic [3:0][15:0]  data;
        logic [2:0]        shape;
        logic [1:0]        rotation;
        logic signed [5:0] x;
        logic signed [5:0] y;
    } tetromino_ctrl;

endpackage

interface piece_controller_if;
    import piece_pkg::*;

    tetromino_ctrl gen_t;
    logic          gen_enable;
    tetromino_ctrl piece;
    logic          piece_valid;
    logic          lock_valid;
    logic          lock_ready;
    logic          game_over;
`ifdef PIECE_GHOST_EN
    logic [5:0]    ghost_y;
    logic          ghost_valid;

    modport master (
        input  gen_t, lock_ready,
        output gen_enable, piece, piece_valid, lock_valid, game_over,
        output ghost_y, ghost_valid
    );
    modport slave (
        output gen_t, lock_ready,
        input  gen_enable, piece, piece_valid, lock_valid, game_over,
        input  ghost_y, ghost_valid
    );
`else
    modport master (
        input  gen_t, lock_ready,
        output gen_enable, piece, piece_valid, lock_valid, game_over
    );
    modport slave (
        output gen_t, lock_ready,
        input  gen_enable, piece, piece_valid, lock_valid, game_over
    );
`endif

endinterface

// File: rtl/piece_controller.sv
// Active-piece FSM: spawn request, moves/rotation/gravity with collision
// checks, hard drop and valid/ready lock hand-off to the board writer.
// Ports: clk, rst (sync, active-high), start, tick, cmd_* pulses, board
// occupancy (bit y*GRID_W+x), bus (piece_controller_if.master).
// Optional macro PIECE_GHOST_EN adds the ghost landing-row scanner.

module piece_controller
    import piece_pkg::*;
#(
    parameter int GRID_W     = 10,
    parameter int GRID_H     = 20,
    parameter int DROP_TICKS = 50
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     tick,
    input  logic                     cmd_left,
    input  logic                     cmd_right,
    input  logic                     cmd_rotate,
    input  logic                     cmd_down,
    input  logic                     cmd_hard_drop,
    input  logic [GRID_W*GRID_H-1:0] board,
    piece_controller_if.master       bus
);

    localparam int CW = (DROP_TICKS > 1) ? $clog2(DROP_TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DROP_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE,
        SPAWN_REQ,
        SPAWN_WAIT,
        SPAWN_CHECK,
        FALLING,
        DROPPING,
        LOCK,
        GAME_OVER
    } state_t;

    state_t        state, state_n;
    tetromino_ctrl piece_q, piece_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic          pv_q, pv_n;
    logic          lv_q, lv_n;
    logic          go_q, go_n;

    // True if any set cell of the mask at (x,y) is off-board or occupied.
    function automatic logic hit(
        input logic [15:0]              cells,
        input logic signed [5:0]        x,
        input logic signed [5:0]        y,
        input logic [GRID_W*GRID_H-1:0] brd
    );
        logic h;
        int   cx;
        int   cy;
        h = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (cells[15 - (r * 4 + c)]) begin
                    cx = int'(x) + c;
                    cy = int'(y) + r;
                    if (cx < 0 || cx >= GRID_W || cy >= GRID_H)
                        h = 1'b1;
                    else if (cy >= 0 && brd[cy * GRID_W + cx])
                        h = 1'b1;
                end
            end
        end
        return h;
    endfunction

    logic [15:0] cur;
    logic [1:0]  rot_nx;
    logic [5:0]  x_l, x_r, y_d;
    logic        hit_l, hit_r, hit_d, hit_rot, hit_spawn;

    assign cur    = piece_q.data[piece_q.rotation];
    assign rot_nx = piece_q.rotation + 2'd1;
    assign x_l    = piece_q.x - 6'd1;
    assign x_r    = piece_q.x + 6'd1;
    assign y_d    = piece_q.y + 6'd1;

    assign hit_l     = hit(cur, x_l, piece_q.y, board);
    assign hit_r     = hit(cur, x_r, piece_q.y, board);
    assign hit_d     = hit(cur, piece_q.x, y_d, board);
    assign hit_rot   = hit(piece_q.data[rot_nx], piece_q.x, piece_q.y, board);
    assign hit_spawn = hit(bus.gen_t.data[bus.gen_t.rotation],
                           bus.gen_t.x, bus.gen_t.y, board);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            piece_q <= '0;
            cnt_q   <= '0;
            pv_q    <= 1'b0;
            lv_q    <= 1'b0;
            go_q    <= 1'b0;
        end else begin
            state   <= state_n;
            piece_q <= piece_n;
            cnt_q   <= cnt_n;
            pv_q    <= pv_n;
            lv_q    <= lv_n;
            go_q    <= go_n;
        end
    end

    always_comb begin
        state_n = state;
        piece_n = piece_q;
        cnt_n   = cnt_q;
        pv_n    = pv_q;
        lv_n    = lv_q;
        go_n    = go_q;
        unique case (state)
            IDLE: begin
                if (start)
                    state_n = SPAWN_REQ;
            end
            SPAWN_REQ: begin
                state_n = SPAWN_WAIT;
            end
            SPAWN_WAIT: begin
                state_n = SPAWN_CHECK;
            end
            SPAWN_CHECK: begin
                piece_n = bus.gen_t;
                cnt_n   = '0;
                if (hit_spawn) begin
                    state_n = GAME_OVER;
                    go_n    = 1'b1;
                    pv_n    = 1'b0;
                end else begin
                    state_n = FALLING;
                    pv_n    = 1'b1;
                end
            end
            FALLING: begin
                // One action per cycle; anything of lower priority is lost.
                if (cmd_hard_drop) begin
                    state_n = DROPPING;
                end else if (cmd_rotate) begin
                    if (!hit_rot)
                        piece_n.rotation = rot_nx;
                end else if (cmd_left) begin
                    if (!hit_l)
                        piece_n.x = x_l;
                end else if (cmd_right) begin
                    if (!hit_r)
                        piece_n.x = x_r;
                end else if (cmd_down || (tick && cnt_q == LAST)) begin
                    cnt_n = '0;
                    if (!hit_d) begin
                        piece_n.y = y_d;
                    end else begin
                        state_n = LOCK;
                        lv_n    = 1'b1;
                    end
                end else if (tick) begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            DROPPING: begin
                if (!hit_d) begin
                    piece_n.y = y_d;
                end else begin
                    state_n = LOCK;
                    lv_n    = 1'b1;
                end
            end
            LOCK: begin
                if (lv_q && bus.lock_ready) begin
                    pv_n    = 1'b0;
                    lv_n    = 1'b0;
                    state_n = SPAWN_REQ;
                end
            end
            GAME_OVER: begin
                state_n = GAME_OVER;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.gen_enable  = (state == SPAWN_REQ);
    assign bus.piece       = piece_q;
    assign bus.piece_valid = pv_q;
    assign bus.lock_valid  = lv_q;
    assign bus.game_over   = go_q;

`ifdef PIECE_GHOST_EN
    logic [5:0] gy_q;
    logic [5:0] scan_q;
    logic       gv_q;
    logic       hit_g;
    logic       moved;

    assign hit_g = hit(cur, piece_q.x, scan_q + 6'd1, board);
    assign moved = (piece_n.x != piece_q.x) ||
                   (piece_n.y != piece_q.y) ||
                   (piece_n.rotation != piece_q.rotation);

    // Walks down one row per cycle from the piece; restarts on any move.
    always_ff @(posedge clk) begin
        if (rst || state_n != FALLING) begin
            gy_q   <= '0;
            scan_q <= '0;
            gv_q   <= 1'b0;
        end else if (state != FALLING || moved) begin
            gv_q   <= 1'b0;
            scan_q <= piece_n.y;
        end else if (!gv_q) begin
            if (hit_g) begin
                gy_q <= scan_q;
                gv_q <= 1'b1;
            end else begin
                scan_q <= scan_q + 6'd1;
            end
        end
    end

    assign bus.ghost_y     = gy_q;
    assign bus.ghost_valid = gv_q;
`endif

endmodule

// File: tb/tb_piece_controller.sv
// Scoreboard bench for piece_controller: directed stimulus pushes expected
// events (gen request, piece update, lock offer, game over) for a monitor.

module tb_piece_controller;
    import piece_pkg::*;

    localparam int W = 10;
    localparam int H = 20;

    localparam int EV_GEN   = 0;
    localparam int EV_PIECE = 1;
    localparam int EV_LOCK  = 2;
    localparam int EV_GO    = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           tick = 1'b0;
    logic           cmd_left = 1'b0;
    logic           cmd_right = 1'b0;
    logic           cmd_rotate = 1'b0;
    logic           cmd_down = 1'b0;
    logic           cmd_hard_drop = 1'b0;
    logic [W*H-1:0] board = '0;

    piece_controller_if bus();

    piece_controller #(
        .GRID_W(W),
        .GRID_H(H),
        .DROP_TICKS(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .tick(tick),
        .cmd_left(cmd_left),
        .cmd_right(cmd_right),
        .cmd_rotate(cmd_rotate),
        .cmd_down(cmd_down),
        .cmd_hard_drop(cmd_hard_drop),
        .board(board),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int x;
        int y;
        int rot;
    } ev_t;

    ev_t q[$];
    int  checks = 0;
    int  failures = 0;

    function automatic tetromino_ctrl mk(input logic [63:0] d,
                                         input logic [2:0] s);
        tetromino_ctrl t;
        t.data     = d;
        t.shape    = s;
        t.rotation = 2'd0;
        t.x        = 6'sd3;
        t.y        = 6'sd0;
        return t;
    endfunction

    tetromino_ctrl piece_o;
    tetromino_ctrl piece_i;

    task automatic exp_ev(input int k, input int x, input int y,
                          input int rot);
        ev_t e;
        e.kind = k;
        e.x    = x;
        e.y    = y;
        e.rot  = rot;
        q.push_back(e);
    endtask

    task automatic got(input int k, input int x, input int y,
                       input int rot);
        ev_t e;
        checks++;
        if (q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event kind=%0d x=%0d y=%0d rot=%0d required none",
                     k, x, y, rot);
        end else begin
            e = q.pop_front();
            if (e.kind != k ||
                ((k == EV_PIECE || k == EV_LOCK) &&
                 (e.x != x || e.y != y || e.rot != e.rot + rot - rot ||
                  e.rot != rot))) begin
                failures++;
                $display("FAIL event got kind=%0d x=%0d y=%0d rot=%0d required kind=%0d x=%0d y=%0d rot=%0d",
                         k, x, y, rot, e.kind, e.x, e.y, e.rot);
            end
        end
    endtask

    // Monitor: turns DUT output activity into events and scores them.
    initial begin
        logic pv_p;
        logic lv_p;
        logic go_p;
        int   x_p;
        int   y_p;
        int   r_p;
        int   xi;
        int   yi;
        int   ri;
        pv_p = 1'b0;
        lv_p = 1'b0;
        go_p = 1'b0;
        x_p  = 0;
        y_p  = 0;
        r_p  = 0;
        forever begin
            @(negedge clk);
            xi = $signed(bus.piece.x);
            yi = $signed(bus.piece.y);
            ri = int'(bus.piece.rotation);
            if (rst) begin
                pv_p = 1'b0;
                lv_p = 1'b0;
                go_p = 1'b0;
            end else begin
                if (bus.gen_enable)
                    got(EV_GEN, 0, 0, 0);
                if (bus.piece_valid &&
                    (!pv_p || xi != x_p || yi != y_p || ri != r_p))
                    got(EV_PIECE, xi, yi, ri);
                if (bus.lock_valid && !lv_p)
                    got(EV_LOCK, xi, yi, ri);
                if (bus.game_over && !go_p)
                    got(EV_GO, 0, 0, 0);
                pv_p = bus.piece_valid;
                lv_p = bus.lock_valid;
                go_p = bus.game_over;
            end
            x_p = xi;
            y_p = yi;
            r_p = ri;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic drain(input string name, input int n);
        for (int i = 0; i < n && q.size() != 0; i++)
            @(posedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL %s got=%0d_pending_events required=0",
                     name, q.size());
            q.delete();
        end
    endtask

    task automatic accept();
        bus.lock_ready = 1'b1;
        step();
        bus.lock_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        piece_o = mk({16'h6600, 16'h6600, 16'h6600, 16'h6600}, 3'd1);
        piece_i = mk({16'h4444, 16'h00F0, 16'h2222, 16'h0F00}, 3'd2);
        bus.gen_t      = piece_o;
        bus.lock_ready = 1'b0;

        repeat (3) step();
        chk("rst_gen_enable", int'(bus.gen_enable), 0);
        chk("rst_piece_valid", int'(bus.piece_valid), 0);
        chk("rst_lock_valid", int'(bus.lock_valid), 0);
        chk("rst_game_over", int'(bus.game_over), 0);
        chk("rst_piece_zero", int'(bus.piece != '0), 0);
        rst = 1'b0;
        step();

        // Spawn O, hard drop to the floor, then accept the lock.
        exp_ev(EV_GEN, 0, 0, 0);
        exp_ev(EV_PIECE, 3, 0, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        drain("spawn_o", 20);

        for (int y = 1; y <= 18; y++)
            exp_ev(EV_PIECE, 3, y, 0);
        exp_ev(EV_LOCK, 3, 18, 0);
        cmd_hard_drop = 1'b1;
        step();
        cmd_hard_drop = 1'b0;
        drain("hard_drop", 40);
        repeat (3) step();
        chk("lock_held_valid", int'(bus.lock_valid), 1);
        chk("lock_held_y", int'($signed(bus.piece.y)), 18);

        exp_ev(EV_GEN, 0, 0, 0);
        exp_ev(EV_PIECE, 3, 0, 0);
        accept();
        chk("gen_after_accept", int'(bus.gen_enable), 1);
        chk("lock_cleared", int'(bus.lock_valid), 0);
        drain("respawn", 20);

        // Left walk into the wall, then a left+right collision.
        for (int x = 2; x >= -1; x--)
            exp_ev(EV_PIECE, x, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cmd_left = 1'b1;
            step();
            cmd_left = 1'b0;
            step();
        end
        drain("left_walk", 10);
        chk("left_wall_x", int'($signed(bus.piece.x)), -1);
        cmd_left  = 1'b1;
        cmd_right = 1'b1;
        step();
        cmd_left  = 1'b0;
        cmd_right = 1'b0;
        step();
        chk("left_beats_right", int'($signed(bus.piece.x)), -1);
        exp_ev(EV_PIECE, 0, 0, 0);
        cmd_right = 1'b1;
        step();
        cmd_right = 1'b0;
        drain("right_one", 10);

        for (int y = 1; y <= 18; y++)
            exp_ev(EV_PIECE, 0, y, 0);
        exp_ev(EV_LOCK, 0, 18, 0);
        cmd_hard_drop = 1'b1;
        step();
        cmd_hard_drop = 1'b0;
        drain("hard_drop_x0", 40);

        // Next piece is I; rotation blocked by (5,2), then allowed.
        bus.gen_t = piece_i;
        exp_ev(EV_GEN, 0, 0, 0);
        exp_ev(EV_PIECE, 3, 0, 0);
        accept();
        drain("spawn_i", 20);
        board[2 * W + 5] = 1'b1;
        cmd_rotate = 1'b1;
        step();
        cmd_rotate = 1'b0;
        repeat (2) step();
        chk("rotate_blocked", int'(bus.piece.rotation), 0);
        board[2 * W + 5] = 1'b0;
        exp_ev(EV_PIECE, 3, 0, 1);
        cmd_rotate = 1'b1;
        step();
        cmd_rotate = 1'b0;
        drain("rotate_free", 10);

        // Gravity every second tick; cmd_down resets the count.
        exp_ev(EV_PIECE, 3, 1, 1);
        exp_ev(EV_PIECE, 3, 2, 1);
        for (int i = 0; i < 4; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            step();
        end
        drain("gravity", 10);
        exp_ev(EV_PIECE, 3, 3, 1);
        exp_ev(EV_PIECE, 3, 4, 1);
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
        cmd_down = 1'b1;
        step();
        cmd_down = 1'b0;
        step();
        chk("down_y", int'($signed(bus.piece.y)), 3);
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
        chk("down_cleared_cnt", int'($signed(bus.piece.y)), 3);
        tick = 1'b1;
        step();
        tick = 1'b0;
        drain("down_then_ticks", 10);

        for (int y = 5; y <= 16; y++)
            exp_ev(EV_PIECE, 3, y, 1);
        exp_ev(EV_LOCK, 3, 16, 1);
        cmd_hard_drop = 1'b1;
        step();
        cmd_hard_drop = 1'b0;
        drain("hard_drop_i", 40);

        // Spawn area filled: next spawn ends the game.
        bus.gen_t = piece_o;
        for (int y = 0; y < 2; y++)
            for (int x = 3; x <= 6; x++)
                board[y * W + x] = 1'b1;
        exp_ev(EV_GEN, 0, 0, 0);
        exp_ev(EV_GO, 0, 0, 0);
        accept();
        drain("game_over", 20);
        start         = 1'b1;
        cmd_left      = 1'b1;
        tick          = 1'b1;
        step();
        start         = 1'b0;
        cmd_left      = 1'b0;
        tick          = 1'b0;
        cmd_hard_drop = 1'b1;
        step();
        cmd_hard_drop = 1'b0;
        repeat (10) step();
        chk("go_sticky", int'(bus.game_over), 1);
        chk("go_piece_valid", int'(bus.piece_valid), 0);
        chk("go_lock_valid", int'(bus.lock_valid), 0);
        chk("go_gen_enable", int'(bus.gen_enable), 0);

        rst = 1'b1;
        repeat (2) step();
        chk("rst2_game_over", int'(bus.game_over), 0);
        chk("rst2_piece_zero", int'(bus.piece != '0), 0);
        rst = 1'b0;
        board = '0;
        step();

`ifdef PIECE_GHOST_EN
        exp_ev(EV_GEN, 0, 0, 0);
        exp_ev(EV_PIECE, 3, 0, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        drain("ghost_spawn", 20);
        for (int i = 0; i < 30 && !bus.ghost_valid; i++)
            step();
        chk("ghost_valid", int'(bus.ghost_valid), 1);
        chk("ghost_y", int'(bus.ghost_y), 18);
        exp_ev(EV_PIECE, 2, 0, 0);
        cmd_left = 1'b1;
        step();
        cmd_left = 1'b0;
        chk("ghost_cleared", int'(bus.ghost_valid), 0);
        for (int i = 0; i < 30 && !bus.ghost_valid; i++)
            step();
        chk("ghost_valid_again", int'(bus.ghost_valid), 1);
        chk("ghost_y_again", int'(bus.ghost_y), 18);
        drain("ghost_left", 5);
`endif

        repeat (3) step();
        drain("final_queue", 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/piece_controller.md
Name: piece_controller

Overview:
- Active-piece state machine directly downstream of the tetromino generator.
- Requests a new piece by pulsing the generator's enable, then samples its current-piece output and checks the spawn position for game over.
- Applies player commands and gravity, with collision checks against the board occupancy.
- Hands the landed piece to the board writer through a valid/ready lock handshake.

Parameters:
- GRID_W, 10, board width in cells
- GRID_H, 20, board height in cells
- DROP_TICKS, 50, tick pulses per gravity step (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse; leaves IDLE
- tick  in  1  one-cycle game tick pulse
- cmd_left, cmd_right, cmd_rotate, cmd_down, cmd_hard_drop  in  1 each  one-cycle command pulses
- board  in  GRID_W*GRID_H  occupancy; bit index = y*GRID_W + x
- gen_t  in  tetromino_ctrl  generator current piece
- gen_enable  out  1  one-cycle request to generator
- piece  out  tetromino_ctrl  active piece (shape, rotation, x, y)
- piece_valid  out  1  piece is live
- lock_valid  out  1  landed piece offered to board writer
- lock_ready  in  1  board writer accepts
- game_over  out  1  sticky spawn-collision flag

Behaviour:
- Reset values: all outputs 0; piece all-zero; FSM in IDLE; gravity counter 0.
- Shape encoding: tetromino.data[rotation] is 16 bits, row-major. Bit 15 = row 0 col 0; bit 0 = row 3 col 3. Cell (r,c) lies at board (x+c, y+r).
- Coordinates: x and y are treated as signed, computed internally at 6 bits.
- Collision: a candidate collides if any set cell has x+c<0, x+c≥GRID_W, y+r≥GRID_H, or a set board bit. Cells with y+r<0 cannot occur.
- FSM states:
  - IDLE: on start -> SPAWN_REQ.
  - SPAWN_REQ: gen_enable=1 for exactly 1 cycle -> SPAWN_WAIT.
  - SPAWN_WAIT: 1 cycle, lets the generator register the new piece -> SPAWN_CHECK.
  - SPAWN_CHECK: load piece<=gen_t and clear the gravity counter. On collision -> GAME_OVER; otherwise piece_valid=1 -> FALLING.
  - FALLING: at most one action per cycle. Priority: hard_drop > rotate > left > right > down > gravity; lower-priority commands in the same cycle are dropped.
    - Left/right: x∓1 only if the candidate is free; otherwise no change.
    - Rotate: candidate rotation (rotation+1) mod 4 with the shape taken from gen-supplied tetromino.data. Applied if free; otherwise no change (no wall kicks).
    - Down or gravity step: if y+1 is free, y<=y+1 and the counter clears; otherwise -> LOCK.
    - Gravity: the counter increments on tick. When a tick arrives with counter==DROP_TICKS-1, a gravity step is attempted. cmd_down also clears the counter.
    - Hard drop -> DROPPING.
  - DROPPING: y+1 per cycle while free, commands ignored. On the first collision -> LOCK.
  - LOCK: lock_valid=1 with piece held stable. When lock_valid&&lock_ready: piece_valid<=0 and lock_valid<=0 -> SPAWN_REQ.
  - GAME_OVER: game_over=1, piece_valid=0. Only rst leaves this state.
- Commands and ticks outside FALLING are dropped, except ticks and cmd_down in the cycle a lock begins, which have no effect.
- start outside IDLE is ignored.
- rst mid-operation: immediate return to reset values; any outstanding lock is abandoned.
- The board input must be stable while the FSM is outside IDLE/LOCK; the board writer updates it only on lock acceptance.

Optional Feature:
- Macro: PIECE_GHOST_EN.
- With the macro defined, two extra outputs exist: ghost_y (6 bits) and ghost_valid (1 bit).
  - Any change to piece x/y/rotation clears ghost_valid and restarts a scan from the current y.
  - The scan advances one row per cycle until the next row collides, then sets ghost_y to the landing y and ghost_valid=1.
  - Both outputs are 0 at reset and outside FALLING.
- Without the macro: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Empty board, start, gen_t=O (rot0, x=3, y=0) -> gen_enable pulses once, 2 cycles later piece_valid=1 with y=0.
  - Then cmd_hard_drop -> lock_valid=1 with y=18 (cells rows 18-19, cols 4-5).
  - Then lock_ready=1 -> new gen_enable next cycle.
- O at x=3, five cmd_left pulses -> x=2,1,0,-1; fifth rejected, x stays -1.
  - Then cmd_right and cmd_left in the same cycle -> x=-2 rejected, so no change (left wins priority).
- DROP_TICKS=2, empty board, 4 tick pulses -> y=2. Insert cmd_down after tick 1 -> counter cleared, y=1 then y=2 after two more ticks.
- I piece rot0 at x=3, y=0, board bit (5,2) set, cmd_rotate -> rotation stays 0. Clear the bit and rotate again -> rotation=1.
- Board cells (3..6, 0..1) all set, start -> game_over=1, piece_valid=0. Later start and commands have no effect until rst.
- With PIECE_GHOST_EN: O at y=0, empty board -> ghost_valid within 19 cycles, ghost_y=18. Then cmd_left -> ghost_valid drops, then returns with ghost_y=18.
